// File: rtl/itrx_amba2_apb_pkg.sv
// Shared APB type definitions.
// Transfer direction encoding used by APB requesters.
package itrx_amba2_apb_pkg;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } te_pwrite;

endpackage

// File: rtl/itrx_apb_master.sv
// Single-transfer APB3/APB4 requester with wait states,
// slave-error reporting and a saturating hang timeout.
module itrx_apb_master
    import itrx_amba2_apb_pkg::*;
#(
    parameter int AW          = 16,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic            pclk,
    input  logic            presetn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    input  logic [DW/8-1:0] req_strb,
    input  logic [2:0]      req_prot,
    output logic            rsp_valid,
    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_err,
    output logic            rsp_timeout,
    output logic            psel,
    output logic            penable,
    output logic            pwrite,
    output logic [AW-1:0]   paddr,
    output logic [DW-1:0]   pwdata,
    output logic [DW/8-1:0] pstrb,
    output logic [2:0]      pprot,
    input  logic [DW-1:0]   prdata,
    input  logic            pready,
    input  logic            pslverr
);

    localparam bit LP_TO_EN = (TIMEOUT_CYC > 0);
    localparam int CW = LP_TO_EN ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] LP_CNT_LAST =
        LP_TO_EN ? CW'(TIMEOUT_CYC - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS
    } state_t;

    state_t            r_state;
    logic              r_psel;
    logic              r_penable;
    te_pwrite          r_pwrite;
    logic [AW-1:0]     r_paddr;
    logic [DW-1:0]     r_pwdata;
    logic [DW/8-1:0]   r_pstrb;
    logic [2:0]        r_pprot;
    logic [CW-1:0]     r_cnt;
    logic              r_rsp_valid;
    logic [DW-1:0]     r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_rsp_timeout;
    logic              w_expire;

    // Counter holds the number of pready-low ACCESS cycles already seen.
    assign w_expire = LP_TO_EN && (r_cnt == LP_CNT_LAST);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state       <= S_IDLE;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= READ;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_pstrb       <= '0;
            r_pprot       <= '0;
            r_cnt         <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_pwrite <= te_pwrite'(req_write);
                        r_paddr  <= req_addr;
                        r_pwdata <= req_wdata;
                        r_pstrb  <= req_write ? req_strb : '0;
                        r_pprot  <= req_prot;
                        r_cnt    <= '0;
                        r_psel   <= 1'b1;
                        r_state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (pready) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= pslverr;
                        if (r_pwrite == READ && !pslverr)
                            r_rsp_rdata <= prdata;
                        r_state     <= S_IDLE;
                    end else if (w_expire) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= S_IDLE;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = (r_state == S_IDLE);
    assign psel        = r_psel;
    assign penable     = r_penable;
    assign pwrite      = r_pwrite;
    assign paddr       = r_paddr;
    assign pwdata      = r_pwdata;
    assign pstrb       = r_pstrb;
    assign pprot       = r_pprot;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;

endmodule
